// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path (fb_writer, fb_addr_calc,
// and pixel_gen's read-address path): geometry, memory shape, FSM states and
// the byte-lane packing rule (even column = low byte, odd column = high byte).
package fb_pkg;

  localparam int FB_W     = 160;          // pixels per row (must be even)
  localparam int FB_H     = 120;          // rows
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 16;           // two pixels per word
  localparam int PIX_W    = 8;            // RRRGGGBB
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int FB_WORDS = FB_W / 2 * FB_H;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    FILL = 3'd4
  } fb_state_e;

  // Lane is simply the column LSB.
  typedef enum logic {
    LANE_LO = 1'b0,
    LANE_HI = 1'b1
  } fb_lane_e;

  // Replace one pixel of a packed word, leaving its neighbour untouched.
  function automatic logic [DATA_W-1:0] merge_pixel(input logic [DATA_W-1:0] word,
                                                    input fb_lane_e          lane,
                                                    input logic [PIX_W-1:0]  color);
    logic [DATA_W-1:0] merged;
    merged = word;
    if (lane == LANE_HI) merged[DATA_W-1 -: PIX_W] = color;
    else                 merged[PIX_W-1:0]         = color;
    return merged;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel coordinate to word address: y*(FB_W/2) + x/2, plus the range check.
// Purely combinational so pixel_gen can reuse it on its read path.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign addr     = ADDR_W'(y) * ADDR_W'(FB_W / 2) + ADDR_W'(x[X_W-1:1]);
  assign in_range = (int'(x) < FB_W) && (int'(y) < FB_H);

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write engine: single-pixel read-modify-write into a 16-bit,
// two-pixel-per-word single-port memory, touching the memory only while
// grant is high. Define FB_FILL_EN to add the whole-frame bulk fill
// (fill_req / fill_color / fill_done).
module fb_writer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              grant,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [X_W-1:0]    req_x,
  input  logic [Y_W-1:0]    req_y,
  input  logic [PIX_W-1:0]  req_color,
  output logic              req_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
`ifdef FB_FILL_EN
  ,
  input  logic              fill_req,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              fill_done
`endif
);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;   // RMW word address, or fill word counter
  logic [DATA_W-1:0] din_q,   din_d;    // merged word, or packed fill colour
  fb_lane_e          lane_q,  lane_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic              err_q,   err_d;
`ifdef FB_FILL_EN
  logic              done_q,  done_d;
`endif

  logic [ADDR_W-1:0] calc_addr;
  logic              calc_in_range;
  logic              fill_start;
  logic              accept;

  fb_addr_calc u_addr_calc (
    .x        (req_x),
    .y        (req_y),
    .addr     (calc_addr),
    .in_range (calc_in_range)
  );

`ifdef FB_FILL_EN
  assign fill_start = (state_q == IDLE) && fill_req;
`else
  assign fill_start = 1'b0;
`endif

  assign req_ready = !rst && (state_q == IDLE) && !fill_start;
  assign accept    = req_valid && req_ready;

  // Write strobe follows grant combinationally so it can never be high
  // outside an owned cycle; the word itself is only written from WR or FILL.
  assign mem_we   = grant && ((state_q == WR) || (state_q == FILL));
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign req_err  = err_q;
  assign busy     = (state_q != IDLE);
`ifdef FB_FILL_EN
  assign fill_done = done_q;
`endif

  // Next-state and datapath updates for the RMW / fill sequencer.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    lane_d  = lane_q;
    color_d = color_q;
    err_d   = 1'b0;
`ifdef FB_FILL_EN
    done_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FB_FILL_EN
        if (fill_start) begin
          state_d = FILL;
          addr_d  = '0;
          din_d   = {fill_color, fill_color};
        end else
`endif
        if (accept) begin
          lane_d  = fb_lane_e'(req_x[0]);
          color_d = req_color;
          if (calc_in_range) begin
            addr_d  = calc_addr;
            state_d = RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD:  if (grant) state_d = RDW;
      RDW: begin
        // Read data is only trusted if the port was ours on both cycles.
        if (grant) begin
          din_d   = merge_pixel(mem_dout, lane_q, color_q);
          state_d = WR;
        end else begin
          state_d = RD;
        end
      end
      WR:  if (grant) state_d = IDLE;
      FILL: begin
`ifdef FB_FILL_EN
        if (grant) begin
          if (addr_q == ADDR_W'(FB_WORDS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any RMW or fill in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      lane_q  <= LANE_LO;
      color_q <= '0;
      err_q   <= 1'b0;
`ifdef FB_FILL_EN
      done_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      lane_q  <= lane_d;
      color_q <= color_d;
      err_q   <= err_d;
`ifdef FB_FILL_EN
      done_q  <= done_d;
`endif
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: single-port memory model with one-cycle
// read latency, a word-array reference of the framebuffer, scenario tasks.
// Fill scenarios are compiled in when FB_FILL_EN is defined.
`timescale 1ns/1ps
module tb_fb_writer;

  localparam int WORDS = 160 / 2 * 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        grant = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x = '0;
  logic [6:0]  req_y = '0;
  logic [7:0]  req_color = '0;
  logic        req_err;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        busy;
`ifdef FB_FILL_EN
  logic        fill_req = 1'b0;
  logic [7:0]  fill_color = '0;
  logic        fill_done;
`endif

  fb_writer dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_color (req_color),
    .req_err   (req_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy)
`ifdef FB_FILL_EN
    ,
    .fill_req  (fill_req),
    .fill_color(fill_color),
    .fill_done (fill_done)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- memory model and write log ----------------
  bit   [15:0] mem      [16384];
  bit   [13:0] log_addr [32768];
  bit   [15:0] log_din  [32768];
  int          wr_cnt   = 0;
  int          viol_cnt = 0;
  logic        poke_en  = 1'b0;
  logic [13:0] poke_addr = '0;
  logic [15:0] poke_data = '0;
`ifdef FB_FILL_EN
  int          done_cnt = 0;
  int          done_wr  = 0;
`endif

  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_din;
      if (wr_cnt < 32768) begin
        log_addr[wr_cnt] <= mem_addr;
        log_din[wr_cnt]  <= mem_din;
      end
      wr_cnt <= wr_cnt + 1;
      if (grant !== 1'b1) viol_cnt <= viol_cnt + 1;
    end
`ifdef FB_FILL_EN
    if (fill_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_wr  <= wr_cnt;
    end
`endif
  end

  // ---------------- reference model ----------------
  bit [15:0] ref_mem [16384];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int word_of(input int x, input int y);
    return y * (160 / 2) + x / 2;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] old, input int x, input logic [7:0] c);
    if (x % 2 == 0) return {old[15:8], c};
    return {c, old[7:0]};
  endfunction

  task automatic poke_word(input int a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = 14'(a); poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drive one pixel request and follow it until the engine is idle again.
  // k counts cycles after the accept cycle; grant is forced low for
  // k in [gap_start, gap_start+gap_len) and the request's word is rewritten
  // in memory at k == poke_k.
  task automatic run_req(input int x, input int y, input logic [7:0] c,
                         input int grant_pct, input int gap_start, input int gap_len,
                         input int poke_k, input logic [15:0] poke_val,
                         output bit acc, output int we_at, output int err_cnt,
                         output int n_wr, output logic [13:0] wa, output logic [15:0] wd,
                         output int we_bad, output bit tmo, output bit rdy_after);
    int w0;
    bit done;
    @(negedge clk);
    req_x = 8'(x); req_y = 7'(y); req_color = c; req_valid = 1'b1; grant = 1'b1;
    #1;
    acc = (req_ready === 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    w0 = wr_cnt; we_at = -1; err_cnt = 0; we_bad = 0; tmo = 1'b1; rdy_after = 1'b0; done = 1'b0;
    for (int k = 1; k <= 80 && !done; k++) begin
      if (k > 1) @(negedge clk);
      if (k >= gap_start && k < gap_start + gap_len) grant = 1'b0;
      else grant = ($urandom_range(0, 99) < grant_pct);
      if (k == poke_k) begin
        poke_en = 1'b1; poke_addr = 14'(word_of(x, y)); poke_data = poke_val;
      end else begin
        poke_en = 1'b0;
      end
      #1;
      if (mem_we === 1'b1 && we_at < 0) we_at = k;
      if (mem_we === 1'b1 && grant !== 1'b1) we_bad++;
      if (req_err === 1'b1) err_cnt++;
      if (busy === 1'b0) begin
        done = 1'b1; tmo = 1'b0; rdy_after = (req_ready === 1'b1);
      end
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      grant = 1'b1; poke_en = 1'b0;
      #1;
      if (req_err === 1'b1) err_cnt++;
    end
    n_wr = wr_cnt - w0;
    wa = (n_wr > 0) ? log_addr[w0] : 14'h0;
    wd = (n_wr > 0) ? log_din[w0]  : 16'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (mem_we !== 1'b0)   begin n_bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
    n_cmp++; if (mem_addr !== 14'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
    n_cmp++; if (mem_din !== 16'h0) begin n_bad++; $display("FAIL reset_din got=%h want=0", mem_din); end
    n_cmp++; if (req_err !== 1'b0)  begin n_bad++; $display("FAIL reset_err got=%b want=0", req_err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_directed();
    bit acc, tmo, rdy; int we_at, errs, nw, wb; logic [13:0] wa; logic [15:0] wd;
    poke_word(37, 16'hA5A5);
    run_req(74, 0, 8'h3C, 100, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    ref_mem[37] = exp_word(ref_mem[37], 74, 8'h3C);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL dir_accept got=%b want=1", acc); end
    n_cmp++; if (we_at != 3)   begin n_bad++; $display("FAIL dir_latency got=%0d want=3", we_at); end
    n_cmp++; if (nw != 1)      begin n_bad++; $display("FAIL dir_nwrites got=%0d want=1", nw); end
    n_cmp++; if (wa !== 14'd37) begin n_bad++; $display("FAIL dir_addr got=%0d want=37", wa); end
    n_cmp++; if (wd !== ref_mem[37]) begin n_bad++; $display("FAIL dir_din_even got=%h want=%h", wd, ref_mem[37]); end
    run_req(75, 0, 8'hE0, 100, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    ref_mem[37] = exp_word(ref_mem[37], 75, 8'hE0);
    n_cmp++; if (nw != 1 || wa !== 14'd37 || wd !== ref_mem[37])
      begin n_bad++; $display("FAIL dir_din_odd got=%0d@%0d:%h want=1@37:%h", nw, wa, wd, ref_mem[37]); end
  endtask

  task automatic test_corners();
    bit acc, tmo, rdy; int we_at, errs, nw, wb; logic [13:0] wa; logic [15:0] wd;
    poke_word(9599, 16'h5A5A);
    run_req(159, 119, 8'hFF, 100, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    ref_mem[9599] = exp_word(ref_mem[9599], 159, 8'hFF);
    n_cmp++; if (nw != 1 || wa !== 14'd9599 || wd !== ref_mem[9599])
      begin n_bad++; $display("FAIL corner_max got=%0d@%0d:%h want=1@9599:%h", nw, wa, wd, ref_mem[9599]); end
    run_req(160, 0, 8'h12, 100, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL corner_x_err got=%0d want=1", errs); end
    n_cmp++; if (nw != 0)   begin n_bad++; $display("FAIL corner_x_nowrite got=%0d want=0", nw); end
    n_cmp++; if (rdy !== 1'b1 || tmo) begin n_bad++; $display("FAIL corner_x_ready got=%b want=1", rdy); end
    run_req(0, 120, 8'h34, 100, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    n_cmp++; if (errs != 1 || nw != 0)
      begin n_bad++; $display("FAIL corner_y_err got=%0d/%0d want=1/0", errs, nw); end
  endtask

  task automatic test_grant_gap();
    bit acc, tmo, rdy; int we_at, errs, nw, wb; logic [13:0] wa; logic [15:0] wd; int a;
    a = word_of(10, 5);
    poke_word(a, 16'h1234);
    // Word changes while the port is lost; the merge must use the re-read value.
    run_req(10, 5, 8'h77, 100, 2, 5, 3, 16'hC3D4, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    ref_mem[a] = exp_word(16'hC3D4, 10, 8'h77);
    n_cmp++; if (nw != 1 || wa !== 14'(a) || wd !== ref_mem[a])
      begin n_bad++; $display("FAIL gap_data got=%0d@%0d:%h want=1@%0d:%h", nw, wa, wd, a, ref_mem[a]); end
    n_cmp++; if (we_at != 9) begin n_bad++; $display("FAIL gap_reread got=%0d want=9", we_at); end
    n_cmp++; if (wb != 0)    begin n_bad++; $display("FAIL gap_we_no_grant got=%0d want=0", wb); end
  endtask

  task automatic test_reset_mid();
    bit acc, tmo, rdy; int we_at, errs, nw, wb; logic [13:0] wa; logic [15:0] wd; int a, w0;
    a = word_of(20, 3);
    poke_word(a, 16'hBEEF);
    @(negedge clk); req_x = 8'd20; req_y = 7'd3; req_color = 8'h42; req_valid = 1'b1; grant = 1'b1;
    @(negedge clk); req_valid = 1'b0; grant = 1'b1;
    @(negedge clk); grant = 1'b1;
    @(negedge clk); grant = 1'b0;
    w0 = wr_cnt;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_wr got=%b want=1", busy); end
    @(negedge clk); grant = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL rmid_abort got=we%b/busy%b want=0/0", mem_we, busy); end
    @(negedge clk); grant = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmid_we_in_reset got=%b want=0", mem_we); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (wr_cnt != w0 || mem[a] !== 16'hBEEF)
      begin n_bad++; $display("FAIL rmid_unchanged got=%0d:%h want=%0d:beef", wr_cnt, mem[a], w0); end
    run_req(20, 3, 8'h42, 100, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
    ref_mem[a] = exp_word(ref_mem[a], 20, 8'h42);
    n_cmp++; if (nw != 1 || wd !== ref_mem[a])
      begin n_bad++; $display("FAIL rmid_after got=%0d:%h want=1:%h", nw, wd, ref_mem[a]); end
  endtask

  task automatic test_back_to_back();
    int wr_cyc[$]; int n_acc, w0, bad; bit adv; int a;
    n_acc = 0; adv = 1'b0; w0 = wr_cnt; bad = 0;
    @(negedge clk);
    grant = 1'b1; req_valid = 1'b1; req_x = 8'd0; req_y = 7'd50; req_color = 8'h11;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (n_acc == 4) req_valid = 1'b0;
        else begin req_x = 8'(2 * n_acc); req_color = 8'(17 * (n_acc + 1)); end
      end
      #1;
      if (mem_we === 1'b1) wr_cyc.push_back(cyc);
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        a = word_of(int'(req_x), 50);
        ref_mem[a] = exp_word(ref_mem[a], int'(req_x), req_color);
        n_acc++; adv = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (wr_cyc.size() != 4) bad++;
    else for (int i = 0; i < 4; i++) begin
      if (wr_cyc[i] != 3 + 4 * i) bad++;
      if (log_din[w0 + i] !== ref_mem[word_of(2 * i, 50)]) bad++;
    end
    n_cmp++; if (bad != 0 || n_acc != 4)
      begin n_bad++; $display("FAIL b2b_throughput got=%0d writes/%0d accepts/%0d errs want=4/4/0", wr_cyc.size(), n_acc, bad); end
  endtask

  task automatic test_random();
    bit acc, tmo, rdy; int we_at, errs, nw, wb; logic [13:0] wa; logic [15:0] wd;
    int x, y, r, a, diff; logic [7:0] c;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 99);
      c = 8'($urandom);
      if (r < 15) begin x = $urandom_range(160, 255); y = $urandom_range(0, 127); end
      else if (r < 25) begin x = $urandom_range(0, 159); y = $urandom_range(120, 127); end
      else begin x = $urandom_range(0, 159); y = $urandom_range(0, 119); end
      run_req(x, y, c, 60, 0, 0, -1, 16'h0, acc, we_at, errs, nw, wa, wd, wb, tmo, rdy);
      if (x < 160 && y < 120) begin
        a = word_of(x, y);
        ref_mem[a] = exp_word(ref_mem[a], x, c);
        n_cmp++; if (tmo || nw != 1 || wa !== 14'(a) || wd !== ref_mem[a] || errs != 0 || wb != 0)
          begin n_bad++; $display("FAIL rand_write[%0d] (%0d,%0d) got=%0d@%0d:%h err%0d want=1@%0d:%h err0", i, x, y, nw, wa, wd, errs, a, ref_mem[a]); end
      end else begin
        n_cmp++; if (tmo || nw != 0 || errs != 1 || rdy !== 1'b1)
          begin n_bad++; $display("FAIL rand_reject[%0d] (%0d,%0d) got=%0d writes err%0d rdy%b want=0 err1 rdy1", i, x, y, nw, errs, rdy); end
      end
    end
    diff = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) diff++;
    n_cmp++; if (diff != 0) begin n_bad++; $display("FAIL rand_image got=%0d words differ want=0", diff); end
  endtask

`ifdef FB_FILL_EN
  task automatic run_fill(input logic [7:0] fc, input bit half,
                          output bit rdy_entry, output int n_wr, output int n_badlog,
                          output int n_done, output int done_at, output bit tmo);
    int w0, d0;
    bit done;
    @(negedge clk);
    grant = 1'b1; fill_req = 1'b1; fill_color = fc;
    req_valid = 1'b1; req_x = 8'd5; req_y = 7'd5; req_color = 8'hAA;
    #1;
    rdy_entry = (req_ready === 1'b1);
    @(negedge clk);
    fill_req = 1'b0; req_valid = 1'b0; fill_color = ~fc;
    w0 = wr_cnt; d0 = done_cnt; tmo = 1'b1; done = 1'b0;
    for (int k = 0; k < 25000 && !done; k++) begin
      if (k > 0) @(negedge clk);
      grant = half ? ~grant : 1'b1;
      fill_req = (k == 100);
      #1;
      if (done_cnt > d0) begin done = 1'b1; tmo = 1'b0; end
    end
    for (int j = 0; j < 3; j++) begin @(negedge clk); grant = 1'b1; fill_req = 1'b0; end
    #1;
    n_wr = wr_cnt - w0;
    n_done = done_cnt - d0;
    done_at = done_wr - w0;
    n_badlog = 0;
    for (int i = 0; i < n_wr && i < WORDS + 8; i++)
      if (log_addr[w0 + i] !== 14'(i) || log_din[w0 + i] !== {fc, fc}) n_badlog++;
  endtask

  task automatic test_fill_priority();
    bit rdy, tmo; int nw, nb, nd, da;
    run_fill(8'h1F, 1'b0, rdy, nw, nb, nd, da, tmo);
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 16'h1F1F;
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL fill_prio_ready got=%b want=0", rdy); end
    n_cmp++; if (tmo || nw != WORDS) begin n_bad++; $display("FAIL fill_count got=%0d want=%0d", nw, WORDS); end
    n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL fill_order_data got=%0d bad want=0", nb); end
    n_cmp++; if (nd != 1 || da != WORDS)
      begin n_bad++; $display("FAIL fill_done got=%0d pulses after %0d writes want=1 after %0d", nd, da, WORDS); end
    n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1)
      begin n_bad++; $display("FAIL fill_idle got=busy%b/rdy%b want=0/1", busy, req_ready); end
  endtask

  task automatic test_fill_half_grant();
    bit rdy, tmo; int nw, nb, nd, da; logic [7:0] fc;
    fc = 8'($urandom);
    run_fill(fc, 1'b1, rdy, nw, nb, nd, da, tmo);
    n_cmp++; if (tmo || nw != WORDS || nb != 0 || nd != 1)
      begin n_bad++; $display("FAIL fill_half got=%0d writes/%0d bad/%0d done want=%0d/0/1", nw, nb, nd, WORDS); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_corners();
    test_grant_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef FB_FILL_EN
    test_fill_priority();
    test_fill_half_grant();
`endif
    @(negedge clk);
    n_cmp++; if (viol_cnt != 0) begin n_bad++; $display("FAIL we_without_grant got=%0d want=0", viol_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Framebuffer write engine upstream of the display path.
- Accepts pixel-write requests in downscaled 160x120 coordinates; each coordinate is one 4x4 block of the 640x480 display.
- Packs two 8-bit RRRGGGBB pixels per 16-bit word of the 14-bit-address single-port framebuffer memory that pixel_gen reads.
- Updates a single pixel by read-modify-write, and optionally bulk-fills the whole frame, only while the memory-window grant is high.

Parameters:
- FB_W, 160, framebuffer width in pixels (must be even).
- FB_H, 120, framebuffer height in pixels.
- ADDR_W, 14, memory address width.
- DATA_W, 16, memory word width (two pixels).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- grant  in  1  memory port owned by this block this cycle (e.g. blanking window).
- req_valid  in  1  pixel write request valid.
- req_ready  out  1  request accepted on the cycle req_valid and req_ready are both high.
- req_x  in  8  pixel column, 0..FB_W-1.
- req_y  in  7  pixel row, 0..FB_H-1.
- req_color  in  8  pixel colour.
- req_err  out  1  one-cycle pulse: the accepted request was out of range and was dropped.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, valid one cycle after the address is presented.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_din=0, req_err=0, busy=0.
  - req_ready=1 once rst deasserts.
- Address and packing:
  - addr = y*(FB_W/2) + x[7:1], computed at ADDR_W bits; the maximum is 9599 for the defaults.
  - Even x is the low byte [7:0]; odd x is the high byte [15:8].
- IDLE:
  - req_ready=1 only in IDLE, and only when no fill is being started.
  - On accept, x, y and color are registered.
  - If x>=FB_W or y>=FB_H: req_err pulses the next cycle and the state stays IDLE (no memory access).
  - Otherwise the state goes to RD.
- RD: drives mem_addr, mem_we=0. If grant=1, go to RDW; otherwise hold in RD.
- RDW:
  - If grant=1: latch mem_dout, merge the colour into the selected byte, go to WR.
  - If grant=0: return to RD and re-read (the data may be stale).
- WR:
  - mem_we=1 only while grant=1, with mem_din = merged word.
  - Returns to IDLE after the granted write cycle.
  - Holds in WR while grant=0, with the merged word retained.
- Latency: with grant held, 4 cycles from accept to write completion (accept, RD, RDW, WR); throughput is one pixel per 4 cycles.
- mem_we is never 1 while grant=0.
- When grant toggles, the RMW stays atomic. No partial write is possible because the single write happens only in WR.
- Reset mid-operation aborts the RMW with no write issued. A fill in progress is abandoned; memory keeps the words already written.

Optional Feature:
- Macro: FB_FILL_EN.
- With the macro defined:
  - Extra ports fill_req (in, 1), fill_color (in, 8) and fill_done (out, 1).
  - fill_req sampled high in IDLE enters FILL. fill_req wins over a simultaneous req_valid, and req_ready is 0 that cycle.
  - FILL writes {fill_color,fill_color} to addresses 0..(FB_W/2*FB_H-1), one word per granted cycle, with no read.
  - The word counter advances only on granted cycles.
  - fill_color is registered at entry.
  - fill_req during FILL is ignored.
  - After the last word: fill_done pulses for 1 cycle and the state returns to IDLE.
- Without the macro: no fill ports, no FILL state, behaviour otherwise identical.

Decomposition:
- Shared package/header fb_pkg:
  - FB_W, FB_H, ADDR_W, DATA_W.
  - FB_WORDS = FB_W/2*FB_H.
  - State encodings IDLE/RD/RDW/WR/FILL.
  - Byte-lane select convention.
- One natural sub-module, fb_addr_calc: combinational-or-registered y*(FB_W/2)+x[7:1] plus the range check. It is reused by pixel_gen's read-address path.

Test Plan:
- Memory word 37 = 16'hA5A5, grant=1, request (x=74,y=0,color=8'h3C) → mem_we pulses once, 3 cycles after accept, with addr=37 and din=16'hA53C. Re-request with x=75, color=8'hE0 → din=16'hE03C.
- Request (x=159,y=119,color=8'hFF) → addr=9599, high byte written. Request (x=160,y=0) → req_err pulse, no mem_we, req_ready back high the next cycle.
- Drop grant for 5 cycles while in RDW → RD is re-entered, the read is repeated after grant returns, exactly one write results with the correct merged data, and mem_we=0 throughout the gap.
- Assert rst during WR with grant=0 → mem_we stays 0, busy=0 immediately, memory is unchanged, and the next request works normally.
- FB_FILL_EN defined, fill_req and req_valid asserted together with fill_color=8'h1F, grant always 1 → the request is not accepted, words 0..9599 are written with 16'h1F1F, and fill_done pulses once after 9600 writes.
- FB_FILL_EN defined, grant at a 50% duty cycle during a fill → the fill still completes with exactly 9600 writes, each address written once, in ascending order.
